// File: rtl/aurora_20g_enc_gen.sv
// aurora_20g_enc_gen: sequence-number test-pattern source for Aurora 20G bring-up.
// Each word is {PATTERN fill, 16-bit running seq}; the far-end checker compares
// bits [15:0] against its own running count. Supports finite/continuous runs,
// a programmable post-acceptance gap and ready/valid back-pressure.
// Optional feature macro: AURORA_ENC_GEN_ERR_INJ_EN (single-bit error injection).
module aurora_20g_enc_gen #(
    parameter int          DATA_WD = 64,
    parameter logic [47:0] PATTERN = 48'hBBBB_CCCC_DDDD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_rst,
    input  logic               cfg_start,
    input  logic               cfg_stop,
    input  logic [31:0]        cfg_burst_len,
    input  logic [15:0]        cfg_gap,
    input  logic               cfg_err_inj,
    input  logic               tx_rdy,
    output logic               tx_vld,
    output logic [DATA_WD-1:0] tx_data,
    output logic               busy,
    output logic               done,
    output logic [31:0]        tx_cnt,
    output logic [31:0]        inj_cnt
);

    localparam int PW = DATA_WD - 16;
    // Fill above the sequence field, truncated or zero-extended to fit.
    localparam logic [PW-1:0] PAT_FILL = PW'(PATTERN);

`ifdef AURORA_ENC_GEN_ERR_INJ_EN
    localparam logic INJ_EN = 1'b1;
`else
    localparam logic INJ_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        seq_q, seq_d;
    logic [31:0]        tx_cnt_q, tx_cnt_d;
    logic [31:0]        word_cnt_q, word_cnt_d;
    logic [31:0]        burst_len_q, burst_len_d;
    logic [15:0]        gap_q, gap_d;
    logic [15:0]        gap_cnt_q, gap_cnt_d;
    logic               stop_pend_q, stop_pend_d;
    logic               inj_pend_q, inj_pend_d;
    logic               inj_word_q, inj_word_d;
    logic [31:0]        inj_cnt_q, inj_cnt_d;
    logic               tx_vld_q, tx_vld_d;
    logic [DATA_WD-1:0] tx_data_q, tx_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept;
    logic               present;

    assign accept = tx_vld_q & tx_rdy;

    // Next-state logic: FSM transitions, counters, word presentation and the
    // synchronous clear, with all registered outputs derived from next state.
    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        tx_cnt_d    = tx_cnt_q;
        word_cnt_d  = word_cnt_q;
        burst_len_d = burst_len_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        stop_pend_d = stop_pend_q;
        inj_pend_d  = inj_pend_q | (INJ_EN & cfg_err_inj);
        inj_word_d  = inj_word_q;
        inj_cnt_d   = inj_cnt_q;
        tx_data_d   = tx_data_q;
        present     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Start wins over a simultaneous stop; stop alone is ignored here.
                if (cfg_start) begin
                    burst_len_d = cfg_burst_len;
                    gap_d       = cfg_gap;
                    word_cnt_d  = '0;
                    stop_pend_d = 1'b0;
                    state_d     = ST_SEND;
                    present     = 1'b1;
                end
            end
            ST_SEND: begin
                // A stop never withdraws the word on offer; it waits for acceptance.
                if (cfg_stop) begin
                    stop_pend_d = 1'b1;
                end
                if (accept) begin
                    seq_d      = seq_q + 16'd1;
                    tx_cnt_d   = tx_cnt_q + 32'd1;
                    word_cnt_d = word_cnt_q + 32'd1;
                    inj_word_d = 1'b0;
                    if (inj_word_q) begin
                        inj_cnt_d  = inj_cnt_q + 32'd1;
                        inj_pend_d = INJ_EN & cfg_err_inj;
                    end
                    if ((burst_len_q != 32'd0) && (word_cnt_d == burst_len_q)) begin
                        state_d = ST_DONE;
                    end else if (stop_pend_q || cfg_stop) begin
                        state_d = ST_IDLE;
                    end else if (gap_q != 16'd0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_q;
                    end else begin
                        present = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (cfg_stop) begin
                    state_d = ST_IDLE;
                end else if (gap_cnt_q <= 16'd1) begin
                    state_d = ST_SEND;
                    present = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Load a fresh word only when one is newly offered so data holds while stalled.
        if (present) begin
            inj_word_d = inj_pend_d;
            tx_data_d  = {PAT_FILL, seq_d[15:1], seq_d[0] ^ inj_pend_d};
        end

        if (cfg_rst) begin
            state_d     = ST_IDLE;
            seq_d       = '0;
            tx_cnt_d    = '0;
            word_cnt_d  = '0;
            burst_len_d = '0;
            gap_d       = '0;
            gap_cnt_d   = '0;
            stop_pend_d = 1'b0;
            inj_pend_d  = 1'b0;
            inj_word_d  = 1'b0;
            inj_cnt_d   = '0;
            tx_data_d   = {PAT_FILL, 16'h0000};
        end

        tx_vld_d = (state_d == ST_SEND);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            seq_q       <= '0;
            tx_cnt_q    <= '0;
            word_cnt_q  <= '0;
            burst_len_q <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
            inj_pend_q  <= 1'b0;
            inj_word_q  <= 1'b0;
            inj_cnt_q   <= '0;
            tx_vld_q    <= 1'b0;
            tx_data_q   <= {PAT_FILL, 16'h0000};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            tx_cnt_q    <= tx_cnt_d;
            word_cnt_q  <= word_cnt_d;
            burst_len_q <= burst_len_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            stop_pend_q <= stop_pend_d;
            inj_pend_q  <= inj_pend_d;
            inj_word_q  <= inj_word_d;
            inj_cnt_q   <= inj_cnt_d;
            tx_vld_q    <= tx_vld_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign tx_vld  = tx_vld_q;
    assign tx_data = tx_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign tx_cnt  = tx_cnt_q;
    assign inj_cnt = inj_cnt_q;

endmodule

// File: tb/tb_aurora_20g_enc_gen.sv
// Directed bench for aurora_20g_enc_gen: expected sequence words are queued as
// each run is started and popped whenever the DUT hands over a word.
module tb_aurora_20g_enc_gen;

    localparam int          DATA_WD = 64;
    localparam logic [47:0] PAT     = 48'hBBBB_CCCC_DDDD;
`ifdef AURORA_ENC_GEN_ERR_INJ_EN
    localparam logic INJ = 1'b1;
`else
    localparam logic INJ = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cfg_rst;
    logic               cfg_start;
    logic               cfg_stop;
    logic [31:0]        cfg_burst_len;
    logic [15:0]        cfg_gap;
    logic               cfg_err_inj;
    logic               tx_rdy;
    logic               tx_vld;
    logic [DATA_WD-1:0] tx_data;
    logic               busy;
    logic               done;
    logic [31:0]        tx_cnt;
    logic [31:0]        inj_cnt;

    always #5 clk = ~clk;

    aurora_20g_enc_gen #(.DATA_WD(DATA_WD), .PATTERN(PAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_rst      (cfg_rst),
        .cfg_start    (cfg_start),
        .cfg_stop     (cfg_stop),
        .cfg_burst_len(cfg_burst_len),
        .cfg_gap      (cfg_gap),
        .cfg_err_inj  (cfg_err_inj),
        .tx_rdy       (tx_rdy),
        .tx_vld       (tx_vld),
        .tx_data      (tx_data),
        .busy         (busy),
        .done         (done),
        .tx_cnt       (tx_cnt),
        .inj_cnt      (inj_cnt)
    );

    int          total = 0;
    int          bad = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    logic [15:0] exp_q[$];
    logic [31:0] vld_hist = '0;
    logic        prev_vld = 1'b0;
    logic        prev_rdy = 1'b0;
    logic        prev_rst = 1'b0;
    logic [63:0] prev_data = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, then return just after the rising edge.
    task automatic step();
        logic [15:0] e;
        @(negedge clk);
        if (prev_vld && !prev_rdy && !prev_rst) begin
            chk("hold_vld", 64'(tx_vld), 64'd1);
            chk("hold_data", tx_data, prev_data);
        end
        if (tx_vld && tx_rdy) begin
            chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("data", tx_data, {PAT, e});
            end
            acc_cnt++;
        end
        if (done) done_cnt++;
        vld_hist  = {vld_hist[30:0], tx_vld};
        prev_vld  = tx_vld;
        prev_rdy  = tx_rdy;
        prev_rst  = cfg_rst;
        prev_data = tx_data;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [31:0] len, input logic [15:0] gap);
        cfg_burst_len = len;
        cfg_gap       = gap;
        cfg_start     = 1'b1;
        step();
        cfg_start     = 1'b0;
    endtask

    initial begin
        int base;
        rst_n = 1'b0; cfg_rst = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0;
        cfg_burst_len = '0; cfg_gap = '0; cfg_err_inj = 1'b0; tx_rdy = 1'b0;
        step(); step();
        chk("rst_vld", 64'(tx_vld), 64'd0);
        chk("rst_data", tx_data, {PAT, 16'h0000});
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_txcnt", 64'(tx_cnt), 64'd0);
        chk("rst_injcnt", 64'(inj_cnt), 64'd0);
        rst_n = 1'b1;
        step();

        // Burst of 4, no gap: four back-to-back words then one done pulse.
        tx_rdy = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));
        start_run(32'd4, 16'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        repeat (4) step();
        chk("t1_acc", 64'(acc_cnt), 64'd4);
        step();
        chk("t1_done", 64'(done_cnt), 64'd1);
        step();
        chk("t1_idle", 64'(busy), 64'd0);
        chk("t1_txcnt", 64'(tx_cnt), 64'd4);

        // Burst of 3 with gap 2: valid pattern 1,0,0,1,0,0,1; seq continues at 4.
        for (int i = 4; i < 7; i++) exp_q.push_back(16'(i));
        start_run(32'd3, 16'd2);
        repeat (7) step();
        chk("t2_vld_pat", 64'(vld_hist[6:0]), 64'h49);
        step();
        chk("t2_done", 64'(done_cnt), 64'd2);
        step();
        chk("t2_txcnt", 64'(tx_cnt), 64'd7);

        // Burst of 5 under back-pressure: data must hold while stalled.
        for (int i = 7; i < 12; i++) exp_q.push_back(16'(i));
        start_run(32'd5, 16'd0);
        base = acc_cnt;
        for (int i = 0; i < 40 && acc_cnt < base + 5; i++) begin
            tx_rdy = (i % 3 == 0);
            step();
        end
        chk("t3_acc", 64'(acc_cnt - base), 64'd5);
        tx_rdy = 1'b1;
        step();
        chk("t3_done", 64'(done_cnt), 64'd3);
        step();
        chk("t3_txcnt", 64'(tx_cnt), 64'd12);

        // Continuous run, stop while stalled: word stays valid until taken, no done.
        for (int i = 12; i < 15; i++) exp_q.push_back(16'(i));
        start_run(32'd0, 16'd0);
        repeat (3) step();
        tx_rdy = 1'b0;
        cfg_stop = 1'b1;
        step();
        cfg_stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_stall_vld", 64'(tx_vld), 64'd1);
        end
        exp_q.push_back(16'd15);
        tx_rdy = 1'b1;
        step();
        step();
        chk("t4_idle_vld", 64'(tx_vld), 64'd0);
        chk("t4_idle_busy", 64'(busy), 64'd0);
        chk("t4_no_done", 64'(done_cnt), 64'd3);
        chk("t4_txcnt", 64'(tx_cnt), 64'd16);

        // Bulk run to bring seq up to FFFE.
        for (int i = 16; i < 65534; i++) exp_q.push_back(16'(i));
        start_run(32'd65518, 16'd0);
        for (int i = 0; i < 70000 && done_cnt < 4; i++) step();
        chk("t5_bulk_done", 64'(done_cnt), 64'd4);
        chk("t5_bulk_txcnt", 64'(tx_cnt), 64'd65534);

        // Wrap FFFE, FFFF, 0000, then synchronous clear while a word is on offer.
        exp_q.push_back(16'hFFFE);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        start_run(32'd0, 16'd0);
        repeat (3) step();
        chk("t5_wrap_txcnt", 64'(tx_cnt), 64'h10001);
        chk("t5_next_word", tx_data, {PAT, 16'h0001});
        tx_rdy = 1'b0;
        cfg_rst = 1'b1;
        step();
        cfg_rst = 1'b0;
        chk("t5_clr_vld", 64'(tx_vld), 64'd0);
        chk("t5_clr_data", tx_data, {PAT, 16'h0000});
        chk("t5_clr_txcnt", 64'(tx_cnt), 64'd0);
        chk("t5_clr_busy", 64'(busy), 64'd0);

        // Single-word burst restarting from seq 0.
        tx_rdy = 1'b1;
        exp_q.push_back(16'h0000);
        start_run(32'd1, 16'd0);
        step();
        step();
        chk("t6_done", 64'(done_cnt), 64'd5);
        step();
        chk("t6_txcnt", 64'(tx_cnt), 64'd1);

        // Stop alone in IDLE is ignored; two inject pulses collapse to one;
        // start together with stop still runs the full burst.
        cfg_stop = 1'b1;
        step();
        cfg_stop = 1'b0;
        chk("t7_stop_idle", 64'(busy), 64'd0);
        cfg_err_inj = 1'b1;
        step();
        step();
        cfg_err_inj = 1'b0;
        exp_q.push_back(16'h0001 ^ {15'd0, INJ});
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'h0003);
        cfg_stop = 1'b1;
        start_run(32'd3, 16'd1);
        cfg_stop = 1'b0;
        for (int i = 0; i < 30 && done_cnt < 6; i++) step();
        chk("t7_done", 64'(done_cnt), 64'd6);
        chk("t7_injcnt", 64'(inj_cnt), 64'(INJ));
        chk("t7_txcnt", 64'(tx_cnt), 64'd4);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
